// File: rtl/rd_credit_ctrl_pkg.sv
// Shared read-path definitions: issue-controller state encoding and the
// default reserve / watchdog constants used by the credit controller.
package rd_credit_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_GRANT       = 2'd1,
        ST_WAIT_CREDIT = 2'd2,
        ST_ERROR       = 2'd3
    } rd_state_e;

    localparam int unsigned RD_SLACK_DEFAULT   = 32'd4;
    localparam int unsigned RD_TIMEOUT_DEFAULT = 32'd255;

endpackage : rd_credit_ctrl_pkg

// File: rtl/rd_watchdog.sv
// Saturating stall counter for the read path: counts cycles without progress
// and pulses expire in the cycle whose increment makes the count reach TIMEOUT.
module rd_watchdog #(
    parameter int unsigned TIMEOUT = 32'd255,
    parameter int unsigned CW      = $clog2(TIMEOUT + 32'd1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);
    localparam logic [CW-1:0] LAST  = CW'(TIMEOUT - 32'd1);
    localparam logic [CW-1:0] ONE   = CW'(32'd1);

    logic [CW-1:0] cnt_r;

    // Stall counter: cleared on progress, otherwise counts up and holds at LIMIT.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (en && (cnt_r != LIMIT)) begin
            cnt_r <= cnt_r + ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Expire fires only on the counting step into LIMIT, so it is a single pulse.
    always_comb begin
        if (en && !clr && (cnt_r == LAST)) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule : rd_watchdog

// File: rtl/rd_credit_ctrl.sv
// Credit-based read-issue controller: grants a read only when the readback
// FIFO is guaranteed room for its data, and tracks lost or spurious returns.
module rd_credit_ctrl
    import rd_credit_ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 32'd1024,
    parameter int unsigned SLACK      = RD_SLACK_DEFAULT,
    parameter int unsigned TIMEOUT    = RD_TIMEOUT_DEFAULT,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 32'd1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rd_req,
    output logic             rd_grant,
    input  logic             rdback_fifo_wren,
    input  logic             rdback_fifo_rden,
    input  logic             err_clr,
    output logic [CNT_W-1:0] used_count,
    output logic [CNT_W-1:0] inflight_count,
    output logic             err_timeout,
    output logic             err_spurious,
    output logic             busy
);

    localparam logic [CNT_W:0]   CREDIT_LIMIT = (CNT_W + 32'd1)'(FIFO_DEPTH - SLACK);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(32'd1);

    rd_state_e        state_r;
    rd_state_e        state_next_s;
    logic             rd_grant_r;
    logic [CNT_W-1:0] used_r;
    logic [CNT_W-1:0] inflight_r;
    logic [CNT_W-1:0] used_next_s;
    logic [CNT_W-1:0] inflight_next_s;
    logic             err_timeout_r;
    logic             err_spurious_r;
    logic             busy_r;

    logic [CNT_W:0]   used_plus_one_s;
    logic [CNT_W:0]   write_off_s;
    logic             credit_ok_s;
    logic             wren_ok_s;
    logic             rden_ok_s;
    logic             spurious_s;
    logic             wd_clr_s;
    logic             wd_en_s;
    logic             expire_s;

    assign used_plus_one_s = {1'b0, used_r} + {{CNT_W{1'b0}}, 1'b1};
    assign credit_ok_s     = (used_plus_one_s <= CREDIT_LIMIT);

    // A return or pop with nothing to account for is flagged and ignored.
    assign wren_ok_s  = rdback_fifo_wren && (inflight_r != '0);
    assign rden_ok_s  = rdback_fifo_rden && (used_r != '0);
    assign spurious_s = (rdback_fifo_wren && (inflight_r == '0)) ||
                        (rdback_fifo_rden && (used_r == '0));

    assign wd_clr_s = rdback_fifo_wren || rd_grant_r || (inflight_r == '0);
    assign wd_en_s  = (inflight_r != '0);

    rd_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr_s),
        .en     (wd_en_s),
        .expire (expire_s)
    );

    // Issue FSM next state; a watchdog expiry overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (rd_req && credit_ok_s) begin
                    state_next_s = ST_GRANT;
                end else if (rd_req) begin
                    state_next_s = ST_WAIT_CREDIT;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_GRANT: begin
                state_next_s = ST_IDLE;
            end
            ST_WAIT_CREDIT: begin
                if (!rd_req) begin
                    state_next_s = ST_IDLE;
                end else if (credit_ok_s) begin
                    state_next_s = ST_GRANT;
                end else begin
                    state_next_s = ST_WAIT_CREDIT;
                end
            end
            ST_ERROR: begin
                if (err_clr) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ERROR;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
        if (expire_s) begin
            state_next_s = ST_ERROR;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // On expiry every in-flight read is written off; a same-cycle pop still counts.
    assign write_off_s = {1'b0, inflight_r} + {{CNT_W{1'b0}}, rden_ok_s};

    // Next values of the reservation and in-flight counters.
    always_comb begin
        used_next_s     = used_r;
        inflight_next_s = inflight_r;
        if (expire_s) begin
            inflight_next_s = '0;
            if ({1'b0, used_r} > write_off_s) begin
                used_next_s = used_r - write_off_s[CNT_W-1:0];
            end else begin
                used_next_s = '0;
            end
        end else begin
            if (rd_grant_r && !wren_ok_s) begin
                inflight_next_s = inflight_r + CNT_ONE;
            end else if (!rd_grant_r && wren_ok_s) begin
                inflight_next_s = inflight_r - CNT_ONE;
            end else begin
                inflight_next_s = inflight_r;
            end
            if (rd_grant_r && !rden_ok_s) begin
                used_next_s = used_r + CNT_ONE;
            end else if (!rd_grant_r && rden_ok_s) begin
                used_next_s = used_r - CNT_ONE;
            end else begin
                used_next_s = used_r;
            end
        end
    end

    // State, grant pulse and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            rd_grant_r <= 1'b0;
            used_r     <= '0;
            inflight_r <= '0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            rd_grant_r <= (state_next_s == ST_GRANT);
            used_r     <= used_next_s;
            inflight_r <= inflight_next_s;
            busy_r     <= (inflight_next_s != '0);
        end
    end

    // Sticky error flags; a new event in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_timeout_r  <= 1'b0;
            err_spurious_r <= 1'b0;
        end else begin
            if (expire_s) begin
                err_timeout_r <= 1'b1;
            end else if (err_clr) begin
                err_timeout_r <= 1'b0;
            end else begin
                err_timeout_r <= err_timeout_r;
            end
            if (spurious_s) begin
                err_spurious_r <= 1'b1;
            end else if (err_clr) begin
                err_spurious_r <= 1'b0;
            end else begin
                err_spurious_r <= err_spurious_r;
            end
        end
    end

    assign rd_grant       = rd_grant_r;
    assign used_count     = used_r;
    assign inflight_count = inflight_r;
    assign err_timeout    = err_timeout_r;
    assign err_spurious   = err_spurious_r;
    assign busy           = busy_r;

endmodule : rd_credit_ctrl

// File: tb/tb_rd_credit_ctrl.sv
// Self-checking bench for rd_credit_ctrl: directed scenarios plus a random
// phase, compared every cycle against a credit/timeout reference model.
module tb_rd_credit_ctrl;

    localparam int FIFO_DEPTH = 16;
    localparam int SLACK      = 4;
    localparam int TIMEOUT    = 20;
    localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             rd_req;
    logic             rd_grant;
    logic             rdback_fifo_wren;
    logic             rdback_fifo_rden;
    logic             err_clr;
    logic [CNT_W-1:0] used_count;
    logic [CNT_W-1:0] inflight_count;
    logic             err_timeout;
    logic             err_spurious;
    logic             busy;

    rd_credit_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .SLACK      (SLACK),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .rd_req           (rd_req),
        .rd_grant         (rd_grant),
        .rdback_fifo_wren (rdback_fifo_wren),
        .rdback_fifo_rden (rdback_fifo_rden),
        .err_clr          (err_clr),
        .used_count       (used_count),
        .inflight_count   (inflight_count),
        .err_timeout      (err_timeout),
        .err_spurious     (err_spurious),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: values the outputs must show after the latest edge.
    int m_used = 0, m_infl = 0, m_grant = 0, m_et = 0, m_es = 0, m_lock = 0;
    int m_cyc = 0, m_last = 0;
    bit chk_en = 1'b0;

    bit sched [64];
    int cyc_d = 0, grants = 0, last_g = -100, gap = 0, g_lat = 0;

    task automatic check(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc_d);
        end
    endtask

    task automatic model_step();
        int cur_g, wr_ok, rd_ok, spur, act, exp_now, credit, sub;
        m_cyc++;
        if (rst) begin
            m_used = 0; m_infl = 0; m_grant = 0; m_et = 0; m_es = 0; m_lock = 0;
            m_last = m_cyc;
            return;
        end
        cur_g   = m_grant;
        wr_ok   = (rdback_fifo_wren && m_infl > 0) ? 1 : 0;
        rd_ok   = (rdback_fifo_rden && m_used > 0) ? 1 : 0;
        spur    = ((rdback_fifo_wren && m_infl == 0) || (rdback_fifo_rden && m_used == 0)) ? 1 : 0;
        act     = (rdback_fifo_wren || cur_g == 1 || m_infl == 0) ? 1 : 0;
        exp_now = (act == 0 && (m_cyc - m_last) == TIMEOUT) ? 1 : 0;
        if (act == 1) m_last = m_cyc;
        credit  = (m_used + 1 <= FIFO_DEPTH - SLACK) ? 1 : 0;
        m_grant = (cur_g == 0 && m_lock == 0 && rd_req && credit == 1 && exp_now == 0) ? 1 : 0;
        if (exp_now == 1) begin
            sub    = m_infl + rd_ok;
            m_used = (m_used > sub) ? m_used - sub : 0;
            m_infl = 0;
        end else begin
            m_infl = m_infl + cur_g - wr_ok;
            m_used = m_used + cur_g - rd_ok;
        end
        if (exp_now == 1) m_et = 1; else if (err_clr) m_et = 0;
        if (spur == 1) m_es = 1; else if (err_clr) m_es = 0;
        m_lock = (exp_now == 1 || (m_lock == 1 && !err_clr)) ? 1 : 0;
    endtask

    // One clock: update model at the edge, then drive the next cycle's inputs.
    task automatic tick();
        @(posedge clk);
        model_step();
        chk_en = 1'b1;
        #2;
        cyc_d++;
        rdback_fifo_wren = sched[cyc_d % 64];
        sched[cyc_d % 64] = 1'b0;
        rdback_fifo_rden = 1'b0;
        err_clr = 1'b0;
        rst = 1'b0;
        if (rd_grant === 1'b1) begin
            grants++;
            gap = cyc_d - last_g;
            last_g = cyc_d;
            if (g_lat > 0) sched[(cyc_d + g_lat) % 64] = 1'b1;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("rd_grant", rd_grant, m_grant);
                check("used_count", used_count, m_used);
                check("inflight_count", inflight_count, m_infl);
                check("err_timeout", err_timeout, m_et);
                check("err_spurious", err_spurious, m_es);
                check("busy", busy, (m_infl != 0) ? 1 : 0);
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench did not terminate");
    end

    initial begin
        int n0, k, t_r, gcyc, to_c;
        bit done;
        rst = 1'b1; rd_req = 1'b0; rdback_fifo_wren = 1'b0;
        rdback_fifo_rden = 1'b0; err_clr = 1'b0;
        tick(); rst = 1'b1;
        tick();
        check("reset_used", used_count, 0);
        check("reset_inflight", inflight_count, 0);
        check("reset_grant", rd_grant, 0);
        check("reset_flags", {err_timeout, err_spurious, busy}, 0);

        // Basic: continuous request, data back 3 cycles after each grant.
        g_lat = 3; n0 = grants; rd_req = 1'b1;
        repeat (40) begin
            tick(); rd_req = 1'b1;
            if (rd_grant === 1'b1 && grants - n0 > 1) check("basic_gap", gap, 2);
        end
        check("basic_grants", grants - n0, 12);
        check("basic_used", used_count, 12);
        check("basic_inflight", inflight_count, 0);
        check("model_basic_used", m_used, 12);

        // Credit release: one pop lets exactly one more read through.
        n0 = grants; gcyc = -1;
        tick(); rd_req = 1'b1; rdback_fifo_rden = 1'b1; t_r = cyc_d;
        repeat (10) begin
            tick(); rd_req = 1'b1;
            if (rd_grant === 1'b1 && gcyc < 0) gcyc = cyc_d;
        end
        check("release_latency", gcyc - t_r, 2);
        check("release_grants", grants - n0, 1);
        check("release_used", used_count, 12);

        // Drain everything.
        rd_req = 1'b0;
        repeat (12) begin tick(); rdback_fifo_rden = 1'b1; end
        tick();
        check("drain_used", used_count, 0);

        // Grant cycle coinciding with both a return and a pop.
        g_lat = 0; k = 0; done = 1'b0; rd_req = 1'b1;
        for (int i = 0; i < 12 && !done; i++) begin
            tick(); rd_req = 1'b1;
            if (rd_grant === 1'b1) begin
                k++;
                if (k == 2) begin
                    rdback_fifo_wren = 1'b1; rdback_fifo_rden = 1'b1;
                    rd_req = 1'b0; done = 1'b1;
                end
            end
        end
        tick();
        check("simul_used", used_count, 1);
        check("simul_inflight", inflight_count, 1);
        check("simul_spurious", err_spurious, 0);
        rdback_fifo_wren = 1'b1; tick();
        rdback_fifo_rden = 1'b1; tick();
        tick();

        // Timeout: three grants whose data never returns.
        g_lat = 0; n0 = grants; rd_req = 1'b1;
        for (int i = 0; i < 20 && grants - n0 < 3; i++) begin
            tick(); rd_req = (grants - n0 < 3);
        end
        rd_req = 1'b0; to_c = -1;
        for (int i = 0; i < 40 && to_c < 0; i++) begin
            tick();
            if (err_timeout === 1'b1) to_c = cyc_d;
        end
        check("timeout_latency", to_c - last_g - 1, TIMEOUT);
        check("timeout_inflight", inflight_count, 0);
        check("timeout_used", used_count, 0);
        check("model_timeout_flag", m_et, 1);
        n0 = grants;
        repeat (10) begin tick(); rd_req = 1'b1; end
        check("error_no_grant", grants - n0, 0);
        tick(); rd_req = 1'b1; err_clr = 1'b1;
        tick(); rd_req = 1'b1;
        check("clr_timeout", err_timeout, 0);
        tick(); rd_req = 1'b0;
        check("post_clr_grant", rd_grant, 1);
        tick(); rdback_fifo_wren = 1'b1;
        tick(); rdback_fifo_rden = 1'b1;
        tick();

        // Spurious return and spurious pop.
        rdback_fifo_wren = 1'b1; tick();
        check("spur_wren_flag", err_spurious, 1);
        check("spur_wren_inflight", inflight_count, 0);
        err_clr = 1'b1; tick();
        check("spur_clr1", err_spurious, 0);
        rdback_fifo_rden = 1'b1; tick();
        check("spur_rden_flag", err_spurious, 1);
        check("spur_rden_used", used_count, 0);
        err_clr = 1'b1; tick();
        check("spur_clr2", err_spurious, 0);

        // Reset mid-operation with used=7, inflight=2.
        n0 = grants; rd_req = 1'b1;
        for (int i = 0; i < 30 && grants - n0 < 7; i++) begin
            g_lat = (grants - n0 < 5) ? 2 : 0;
            tick(); rd_req = (grants - n0 < 7);
        end
        rd_req = 1'b0;
        repeat (3) tick();
        check("pre_reset_used", used_count, 7);
        check("pre_reset_inflight", inflight_count, 2);
        rst = 1'b1; tick();
        check("mid_reset_used", used_count, 0);
        check("mid_reset_inflight", inflight_count, 0);
        check("mid_reset_busy", busy, 0);
        g_lat = 3; rd_req = 1'b1; tick(); rd_req = 1'b0;
        check("post_reset_grant", rd_grant, 1);
        repeat (6) tick();

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            g_lat = ($urandom_range(0, 31) == 0) ? 0 : $urandom_range(1, 6);
            tick();
            if (rd_grant === 1'b1) rd_req = ($urandom_range(0, 1) == 1);
            else if (!rd_req) rd_req = ($urandom_range(0, 2) == 0);
            else rd_req = ($urandom_range(0, 15) != 0);
            rdback_fifo_rden = ($urandom_range(0, 2) == 0);
            rdback_fifo_wren = rdback_fifo_wren | ($urandom_range(0, 63) == 0);
            err_clr = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 499) == 0);
        end
        tick();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_rd_credit_ctrl

// File: doc/rd_credit_ctrl.md
# rd_credit_ctrl

Credit-based read-issue controller for the DDR read-capture path. It sits between the instruction dispatcher and the DFI read-command issue. It grants a read only when the readback FIFO is guaranteed to have room for that read's data, so capture never has to assert `dfi_clk_disable` in steady state. It also tracks outstanding reads and flags lost or spurious read data.

## Interface
Parameters:
- `FIFO_DEPTH`, 1024: readback FIFO depth in 4*DQ_WIDTH-bit words.
- `SLACK`, 4: words held in reserve below `FIFO_DEPTH`, covering the almost-full margin and pipeline skew.
- `TIMEOUT`, 255: maximum cycles allowed between a grant and a data word while reads are in flight.
- `CNT_W`, clog2(FIFO_DEPTH)+1: counter width.

Ports. One clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock.
- `rst`  in  1  synchronous active-high reset.
- `rd_req`  in  1  dispatcher wants to issue one read (one read = one FIFO word); held high until granted.
- `rd_grant`  out  1  registered one-cycle pulse; dispatcher issues the read in this cycle and may drop `rd_req` next cycle.
- `rdback_fifo_wren`  in  1  capture path wrote one word (data returned).
- `rdback_fifo_rden`  in  1  host side popped one word.
- `err_clr`  in  1  clears error flags and leaves ERROR.
- `used_count`  out  CNT_W  reserved words (in flight plus resident in FIFO).
- `inflight_count`  out  CNT_W  granted reads whose data has not yet been written.
- `err_timeout`  out  1  sticky; watchdog expired.
- `err_spurious`  out  1  sticky; `wren` with `inflight==0`, or `rden` with `used==0`.
- `busy`  out  1  high when `inflight_count != 0`.

## Operation
- Credit check: `credit_ok = (used_count + 1) <= (FIFO_DEPTH - SLACK)`, computed at CNT_W+1 bits with no wrap.
- FSM states: IDLE, GRANT, WAIT_CREDIT, ERROR.
  - IDLE: if `rd_req && credit_ok`, go to GRANT. If `rd_req && !credit_ok`, go to WAIT_CREDIT. Otherwise stay.
  - GRANT: `rd_grant=1` for exactly this cycle; next state IDLE. Grants are therefore at least 2 cycles apart.
  - WAIT_CREDIT: go to GRANT when `credit_ok`; go to IDLE if `rd_req` drops.
  - ERROR: no grants; leave to IDLE on `err_clr`.
  - Any state goes to ERROR when the watchdog expires. ERROR takes priority over GRANT.
- `used_count` update: +1 in a GRANT cycle, −1 on `rden`. Both in the same cycle means no change.
- `inflight_count` update: +1 in a GRANT cycle, −1 on `wren`. Both in the same cycle means no change.
- `wren` while `inflight_count==0`: set `err_spurious`; counters unchanged (saturate at 0).
- `rden` while `used_count==0`: set `err_spurious`; counters unchanged (saturate at 0).
- Watchdog:
  - Counter resets to 0 on any `wren`, on any grant, or while `inflight_count==0`; otherwise it increments.
  - When it reaches `TIMEOUT`: set `err_timeout`, force `inflight_count` to 0, and subtract the lost in-flight count from `used_count`.
- `err_clr`: clears both flags. If asserted together with a new error event, the new event wins and the flag stays set.

## Timing
- Reset values: all outputs 0; FSM in IDLE; watchdog 0.
- Reset mid-operation discards all counts. The bench must drain the FIFO separately.
- Grant latency: `rd_req` sampled high at edge N with `credit_ok` gives `rd_grant` high during cycle N+1. Counters reflect the grant after edge N+2.
- `credit_ok` uses registered counters. A `rden` at edge N can enable a grant in cycle N+2 at the earliest.
- `used_count` and `inflight_count` are registered and visible one cycle after the event.
- Error flags assert in the cycle after the triggering event.

## Structure
- Shared package (the project's read-path package): state encoding typedef for IDLE, GRANT, WAIT_CREDIT, ERROR, and the default `SLACK`/`TIMEOUT` constants.
- One natural sub-module, `rd_watchdog`: a saturating cycle counter with clear and enable inputs and an expire pulse output.
- Everything else lives in this module, roughly 200 lines.

## Test plan
Use `FIFO_DEPTH=16`, `SLACK=4`, `TIMEOUT=20` unless noted.
- Basic: `rd_req` held high, no `rden`, `wren` 3 cycles after each grant → exactly 12 grants, 2 cycles apart. Then WAIT_CREDIT with `used_count=12`, `inflight_count=0`.
- Credit release: from the previous end state, pulse `rden` once → a grant 2 cycles later and `used_count` returns to 12.
- Simultaneous events: a GRANT cycle coinciding with both `wren` and `rden` → both counters unchanged, no error.
- Timeout: 3 grants with `wren` never returned → `err_timeout=1` 20 cycles after the last grant. `inflight_count=0`, `used_count=0`, state ERROR, no grants until `err_clr`.
- Spurious: `wren` with `inflight=0` and, separately, `rden` with `used=0` → `err_spurious=1`; counters stay 0; `err_clr` clears the flag.
- Reset mid-operation: assert `rst` with `used=7`, `inflight=2` → next cycle all outputs 0 and state IDLE; a subsequent `rd_req` is granted in 1 cycle.
